rf_debug_ctrl: RTL and testbench

Debug/host controller for the 16-entry register file. It arbitrates the register file's single write port between the pipeline W-stage and a debug write requester. It also runs a register-dump sequencer that walks the peek port and streams each register out over a valid/ready handshake. It sits between the core datapath, the debug/host interface and the register file's WE3/WA3/WD3 and peek_sel/peek_data pins.

---
 rtl/rf_ctrl_pkg.sv | 20 ++
 rtl/rf_debug_ctrl_if.sv | 29 ++
 rtl/rf_dump_seq.sv | 89 ++++++++
 rtl/rf_debug_ctrl.sv | 95 +++++++++
 tb/tb_rf_debug_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file debug/host controller.
package rf_ctrl_pkg;

  localparam int RF_IDX_W  = 4;
  localparam int RF_DATA_W = 32;
  localparam logic [RF_IDX_W-1:0] RF_PC_IDX = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    VALID  = 2'd2,
    DONE   = 2'd3
  } dump_state_t;

  // R15 reads back PC+8 inside the register file, so writes to it are discarded.
  function automatic logic is_pc_idx(input logic [RF_IDX_W-1:0] idx);
    return idx == RF_PC_IDX;
  endfunction

endpackage

// File: rtl/rf_debug_ctrl_if.sv
// Debug/host side of rf_debug_ctrl: debug write request channel and register-dump stream.
interface rf_debug_ctrl_if;
  import rf_ctrl_pkg::*;

  logic                 dbg_wr_valid;
  logic [RF_IDX_W-1:0]  dbg_wr_addr;
  logic [RF_DATA_W-1:0] dbg_wr_data;
  logic                 dbg_wr_ready;
  logic                 dbg_wr_err;

  logic                 dump_start;
  logic                 dump_busy;
  logic                 dump_valid;
  logic                 dump_ready;
  logic [RF_IDX_W-1:0]  dump_idx;
  logic [RF_DATA_W-1:0] dump_data;
  logic                 dump_done;

  modport master (
    output dbg_wr_valid, dbg_wr_addr, dbg_wr_data, dump_start, dump_ready,
    input  dbg_wr_ready, dbg_wr_err, dump_busy, dump_valid, dump_idx, dump_data, dump_done
  );

  modport slave (
    input  dbg_wr_valid, dbg_wr_addr, dbg_wr_data, dump_start, dump_ready,
    output dbg_wr_ready, dbg_wr_err, dump_busy, dump_valid, dump_idx, dump_data, dump_done
  );

endinterface

// File: rtl/rf_dump_seq.sv
// Register-dump sequencer: walks the register file peek port and streams one
// register per beat over a valid/ready handshake.
module rf_dump_seq
  import rf_ctrl_pkg::*;
#(
  parameter int DUMP_LAST = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 dump_start_i,
  input  logic                 dump_ready_i,
  input  logic [RF_DATA_W-1:0] peek_data_i,
  output logic [RF_IDX_W-1:0]  peek_sel_o,
  output logic                 dump_busy_o,
  output logic                 dump_valid_o,
  output logic [RF_IDX_W-1:0]  dump_idx_o,
  output logic [RF_DATA_W-1:0] dump_data_o,
  output logic                 dump_done_o
);

  localparam logic [RF_IDX_W-1:0] LastIdx = RF_IDX_W'(DUMP_LAST);

  dump_state_t          state_q;
  logic [RF_IDX_W-1:0]  idx_q;
  logic [RF_IDX_W-1:0]  idx_d;
  logic [RF_IDX_W-1:0]  peek_sel_q;
  logic [RF_DATA_W-1:0] data_q;
  logic                 busy_q;
  logic                 valid_q;
  logic                 done_q;

  assign idx_d = idx_q + 1'b1;

  // peek_sel is loaded on entry to SAMPLE so the register file read settles within that cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      peek_sel_q <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dump_start_i) begin
            state_q    <= SAMPLE;
            idx_q      <= '0;
            peek_sel_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        SAMPLE: begin
          data_q  <= peek_data_i;
          valid_q <= 1'b1;
          state_q <= VALID;
        end
        VALID: begin
          if (dump_ready_i) begin
            valid_q <= 1'b0;
            if (idx_q == LastIdx) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q      <= idx_d;
              peek_sel_q <= idx_d;
              state_q    <= SAMPLE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign peek_sel_o   = peek_sel_q;
  assign dump_busy_o  = busy_q;
  assign dump_valid_o = valid_q;
  assign dump_idx_o   = idx_q;
  assign dump_data_o  = data_q;
  assign dump_done_o  = done_q;

endmodule

// File: rtl/rf_debug_ctrl.sv
// Register-file debug/host controller: write-port arbitration, debug starvation stall and dump.
// Optional RF_DUMP_FREEZE_EN: stall the core and block debug writes during a dump for an atomic snapshot.
module rf_debug_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int DUMP_LAST    = 15
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 core_we,
  input  logic [RF_IDX_W-1:0]  core_wa,
  input  logic [RF_DATA_W-1:0] core_wd,
  output logic                 core_stall,
  output logic                 WE3,
  output logic [RF_IDX_W-1:0]  WA3,
  output logic [RF_DATA_W-1:0] WD3,
  output logic [RF_IDX_W-1:0]  peek_sel,
  input  logic [RF_DATA_W-1:0] peek_data,
  rf_debug_ctrl_if.slave       dbg
);

  localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);

  logic       dbg_block;
  logic       dbg_hs;
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       starve_q, starve_d;
  logic       wr_err_q, wr_err_d;

`ifdef RF_DUMP_FREEZE_EN
  assign dbg_block  = dbg.dump_busy;
  assign core_stall = starve_q | dbg.dump_busy;
`else
  assign dbg_block  = 1'b0;
  assign core_stall = starve_q;
`endif

  assign dbg_hs           = dbg.dbg_wr_valid & ~core_we & ~dbg_block;
  assign dbg.dbg_wr_ready = dbg_hs;
  assign dbg.dbg_wr_err   = wr_err_q;

  // Core owns the write port whenever it writes; an accepted R15 debug write completes without WE3.
  always_comb begin
    WE3 = dbg_hs & ~is_pc_idx(dbg.dbg_wr_addr);
    WA3 = dbg.dbg_wr_addr;
    WD3 = dbg.dbg_wr_data;
    if (core_we) begin
      WE3 = 1'b1;
      WA3 = core_wa;
      WD3 = core_wd;
    end
  end

  // Counter saturates at the limit so a long starvation cannot wrap and drop the stall.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!dbg.dbg_wr_valid || dbg_hs) begin
      starve_cnt_d = '0;
    end else if (core_we && (starve_cnt_q < StarveMax)) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
    starve_d = dbg.dbg_wr_valid & ~dbg_hs & (starve_cnt_q >= StarveMax);
    wr_err_d = dbg_hs & is_pc_idx(dbg.dbg_wr_addr);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
      wr_err_q     <= wr_err_d;
    end
  end

  rf_dump_seq #(
    .DUMP_LAST(DUMP_LAST)
  ) u_dump_seq (
    .clk_i        (CLK),
    .rst_ni       (RESET_N),
    .dump_start_i (dbg.dump_start),
    .dump_ready_i (dbg.dump_ready),
    .peek_data_i  (peek_data),
    .peek_sel_o   (peek_sel),
    .dump_busy_o  (dbg.dump_busy),
    .dump_valid_o (dbg.dump_valid),
    .dump_idx_o   (dbg.dump_idx),
    .dump_data_o  (dbg.dump_data),
    .dump_done_o  (dbg.dump_done)
  );

endmodule

// File: tb/tb_rf_debug_ctrl.sv
// Directed self-checking bench for rf_debug_ctrl with a small register-file model on the peek port.
module tb_rf_debug_ctrl;

  logic        CLK;
  logic        RESET_N;
  logic        core_we;
  logic [3:0]  core_wa;
  logic [31:0] core_wd;
  logic        core_stall;
  logic        WE3;
  logic [3:0]  WA3;
  logic [31:0] WD3;
  logic [3:0]  peek_sel;
  logic [31:0] peek_data;

  logic [31:0] regs [16];
  logic [31:0] expVal [16];
  logic [31:0] pc8;
  bit          initDone;

  int checks;
  int errors;

  rf_debug_ctrl_if dbgIf ();

  rf_debug_ctrl #(
    .STARVE_LIMIT(8),
    .DUMP_LAST(15)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .core_we    (core_we),
    .core_wa    (core_wa),
    .core_wd    (core_wd),
    .core_stall (core_stall),
    .WE3        (WE3),
    .WA3        (WA3),
    .WD3        (WD3),
    .peek_sel   (peek_sel),
    .peek_data  (peek_data),
    .dbg        (dbgIf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file model: R15 reads PC+8, same-cycle writes bypass to the peek port.
  always @(posedge CLK) begin
    if (!initDone) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'h5A5A_0000 + i;
    end else if (WE3) begin
      regs[WA3] <= WD3;
    end
  end

  always_comb begin
    if (peek_sel == 4'hF) peek_data = pc8;
    else if (WE3 && (WA3 == peek_sel)) peek_data = WD3;
    else peek_data = regs[peek_sel];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cwe, input logic [3:0] cwa, input logic [31:0] cwd,
                               input logic dv, input logic [3:0] da, input logic [31:0] dd);
    core_we            = cwe;
    core_wa            = cwa;
    core_wd            = cwd;
    dbgIf.dbg_wr_valid = dv;
    dbgIf.dbg_wr_addr  = da;
    dbgIf.dbg_wr_data  = dd;
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(dbgIf.dump_valid), 32'd0);
    checkOutput({tag, "_busy"},  32'(dbgIf.dump_busy),  32'd0);
    checkOutput({tag, "_done"},  32'(dbgIf.dump_done),  32'd0);
    checkOutput({tag, "_idx"},   32'(dbgIf.dump_idx),   32'd0);
    checkOutput({tag, "_data"},  dbgIf.dump_data,       32'd0);
    checkOutput({tag, "_peek"},  32'(peek_sel),         32'd0);
    checkOutput({tag, "_stall"}, 32'(core_stall),       32'd0);
    checkOutput({tag, "_err"},   32'(dbgIf.dbg_wr_err), 32'd0);
  endtask

  logic        freezeEn;
  initial begin
`ifdef RF_DUMP_FREEZE_EN
    freezeEn = 1'b1;
`else
    freezeEn = 1'b0;
`endif
  end

  initial begin
    int          beats;
    int          doneCnt;
    int          doneCyc;
    int          cyc;
    bit          prevStall;
    bit          found;
    logic [3:0]  prevIdx;
    logic [31:0] prevData;

    checks   = 0;
    errors   = 0;
    initDone = 1'b0;
    pc8      = 32'hCAFE_0008;
    RESET_N  = 1'b0;
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    dbgIf.dump_start = 1'b0;
    dbgIf.dump_ready = 1'b0;

    for (int i = 0; i < 15; i++) expVal[i] = 32'h5A5A_0000 + i;
    expVal[3]  = 32'hDEAD_BEEF;
    expVal[5]  = 32'h0000_0011;
    expVal[6]  = 32'h0000_0022;
    expVal[7]  = 32'h0000_0077;
    expVal[8]  = 32'h0000_0088;
    expVal[15] = 32'hCAFE_0008;

    #2;
    checkAllZero("reset");
    @(posedge CLK);
    #1;
    initDone = 1'b1;
    RESET_N  = 1'b1;
    nextCycle();

    // Idle debug write to R3.
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b1, 4'h3, 32'hDEAD_BEEF);
    #1;
    checkOutput("idle_ready", 32'(dbgIf.dbg_wr_ready), 32'd1);
    checkOutput("idle_we3",   32'(WE3), 32'd1);
    checkOutput("idle_wa3",   32'(WA3), 32'd3);
    checkOutput("idle_wd3",   WD3,      32'hDEAD_BEEF);
    nextCycle();
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    #1;
    checkOutput("idle_no_err", 32'(dbgIf.dbg_wr_err), 32'd0);

    // Collision: core wins, debug goes the following cycle.
    nextCycle();
    applyStimulus(1'b1, 4'h5, 32'h11, 1'b1, 4'h6, 32'h22);
    #1;
    checkOutput("coll_ready0", 32'(dbgIf.dbg_wr_ready), 32'd0);
    checkOutput("coll_we3_0",  32'(WE3), 32'd1);
    checkOutput("coll_wa3_0",  32'(WA3), 32'd5);
    checkOutput("coll_wd3_0",  WD3,      32'h11);
    nextCycle();
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b1, 4'h6, 32'h22);
    #1;
    checkOutput("coll_ready1", 32'(dbgIf.dbg_wr_ready), 32'd1);
    checkOutput("coll_we3_1",  32'(WE3), 32'd1);
    checkOutput("coll_wa3_1",  32'(WA3), 32'd6);
    checkOutput("coll_wd3_1",  WD3,      32'h22);
    nextCycle();
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);

    // Starvation: core writes 12 cycles in a row against a pending debug write.
    nextCycle();
    applyStimulus(1'b1, 4'h7, 32'h77, 1'b1, 4'h8, 32'h88);
    for (int c = 0; c < 12; c++) begin
      #1;
      checkOutput($sformatf("starve_c%0d", c), 32'(core_stall), 32'(c >= 9));
      nextCycle();
    end
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b1, 4'h8, 32'h88);
    #1;
    checkOutput("starve_hs",       32'(dbgIf.dbg_wr_ready), 32'd1);
    checkOutput("starve_stall_hs", 32'(core_stall), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    #1;
    checkOutput("starve_clear", 32'(core_stall), 32'd0);

    // R15 debug write is accepted but dropped, with an error pulse.
    nextCycle();
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'h1234_5678);
    #1;
    checkOutput("r15_ready", 32'(dbgIf.dbg_wr_ready), 32'd1);
    checkOutput("r15_we3",   32'(WE3), 32'd0);
    checkOutput("r15_err0",  32'(dbgIf.dbg_wr_err), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    #1;
    checkOutput("r15_err1", 32'(dbgIf.dbg_wr_err), 32'd1);
    nextCycle();
    checkOutput("r15_err2", 32'(dbgIf.dbg_wr_err), 32'd0);

    // Dump with backpressure: ready high every third cycle so each beat stalls once.
    nextCycle();
    dbgIf.dump_start = 1'b1;
    dbgIf.dump_ready = 1'b0;
    nextCycle();
    dbgIf.dump_start = 1'b0;
    #1;
    checkOutput("dump_c1_busy",  32'(dbgIf.dump_busy),  32'd1);
    checkOutput("dump_c1_valid", 32'(dbgIf.dump_valid), 32'd0);
    checkOutput("dump_c1_peek",  32'(peek_sel),         32'd0);
    checkOutput("dump_c1_stall", 32'(core_stall),       32'(freezeEn));
    beats     = 0;
    doneCnt   = 0;
    doneCyc   = -1;
    prevStall = 1'b0;
    prevIdx   = '0;
    prevData  = '0;
    cyc       = 2;
    while (cyc < 200 && !(doneCyc >= 0 && cyc > doneCyc + 2)) begin
      nextCycle();
      dbgIf.dump_ready = ((cyc % 3) == 0);
      dbgIf.dump_start = (cyc == 10);
      #1;
      if (prevStall) begin
        checkOutput("hold_idx",  32'(dbgIf.dump_idx), 32'(prevIdx));
        checkOutput("hold_data", dbgIf.dump_data,     prevData);
      end
      if (dbgIf.dump_valid && dbgIf.dump_ready) begin
        if (beats < 16) begin
          checkOutput($sformatf("beat%0d_idx", beats),  32'(dbgIf.dump_idx), 32'(beats));
          checkOutput($sformatf("beat%0d_data", beats), dbgIf.dump_data,     expVal[beats]);
        end
        beats++;
      end
      prevStall = dbgIf.dump_valid && !dbgIf.dump_ready;
      prevIdx   = dbgIf.dump_idx;
      prevData  = dbgIf.dump_data;
      if (dbgIf.dump_done) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = cyc;
      end
      cyc++;
    end
    dbgIf.dump_start = 1'b0;
    dbgIf.dump_ready = 1'b0;
    checkOutput("dump_beats",    32'(beats),           32'd16);
    checkOutput("dump_done_cnt", 32'(doneCnt),         32'd1);
    checkOutput("dump_done_cyc", 32'(doneCyc),         32'd49);
    checkOutput("dump_end_busy", 32'(dbgIf.dump_busy), 32'd0);

    // Reset in the middle of a dump, then restart with ready held high.
    nextCycle();
    dbgIf.dump_ready = 1'b1;
    dbgIf.dump_start = 1'b1;
    nextCycle();
    dbgIf.dump_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      #1;
      if (dbgIf.dump_valid && dbgIf.dump_idx == 4'd7) found = 1'b1;
      else nextCycle();
    end
    checkOutput("mid_idx7_reached", 32'(found), 32'd1);
    RESET_N = 1'b0;
    #1;
    checkAllZero("midrst");
    nextCycle();
    RESET_N = 1'b1;
    nextCycle();
    dbgIf.dump_start = 1'b1;
    doneCyc = -1;
    for (int c = 1; c < 100 && doneCyc < 0; c++) begin
      nextCycle();
      dbgIf.dump_start = 1'b0;
      #1;
      if (c == 1) begin
        checkOutput("restart_peek", 32'(peek_sel),         32'd0);
        checkOutput("restart_busy", 32'(dbgIf.dump_busy),  32'd1);
      end
      if (c == 2) begin
        checkOutput("restart_valid", 32'(dbgIf.dump_valid), 32'd1);
        checkOutput("restart_idx",   32'(dbgIf.dump_idx),   32'd0);
        checkOutput("restart_data",  dbgIf.dump_data,       expVal[0]);
      end
      if (dbgIf.dump_done) doneCyc = c;
    end
    checkOutput("restart_done_cyc", 32'(doneCyc), 32'd33);
    dbgIf.dump_ready = 1'b0;
    nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
